// File: rtl/bus_device_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bus_fifo_pkg
// Shared definitions for the per-device transmit FIFO.
//   ID_W      : width of the destination ID carried in the packet MSBs
//   BCAST_ID  : destination ID that addresses every device
//   pkt_hdr_t : destination header view of a packet
//   dest_of() : extracts the destination header from a 16-bit packet
// Optional feature macro used by the FIFO: FIFO_OVF_CNT_EN.
// -----------------------------------------------------------------------------
package bus_fifo_pkg;

  localparam int          ID_W     = 8;
  localparam logic [7:0]  BCAST_ID = 8'hFF;
  localparam int          PKT_W    = 16;

  typedef struct packed {
    logic [ID_W-1:0] dest;
  } pkt_hdr_t;

  // The destination ID always sits in the top ID_W bits of the packet.
  function automatic pkt_hdr_t dest_of(input logic [PKT_W-1:0] pkt);
    pkt_hdr_t hdr;
    hdr.dest = pkt[PKT_W-1 -: ID_W];
    return hdr;
  endfunction

endpackage

// File: rtl/bus_device_fifo_if.sv
// -----------------------------------------------------------------------------
// bus_device_fifo_if
// Handshake bundle between a device/bus agent (master) and the FIFO (slave).
//   push_in, D_in : device pushes a packet
//   pop           : bus consumes the head packet
//   pndng, D_pop  : FIFO non-empty flag and first-word-fall-through head
//   full, count   : occupancy status
//   overflow      : one-cycle pulse when a push is dropped
//   ovf_cnt       : dropped-push counter (zero unless FIFO_OVF_CNT_EN)
// -----------------------------------------------------------------------------
interface bus_device_fifo_if #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
);
  logic                         push_in;
  logic [pckg_sz-1:0]           D_in;
  logic                         pop;
  logic                         pndng;
  logic [pckg_sz-1:0]           D_pop;
  logic                         full;
  logic [$clog2(depth+1)-1:0]   count;
  logic                         overflow;
  logic [7:0]                   ovf_cnt;

  modport master (
    output push_in, D_in, pop,
    input  pndng, D_pop, full, count, overflow, ovf_cnt
  );

  modport slave (
    input  push_in, D_in, pop,
    output pndng, D_pop, full, count, overflow, ovf_cnt
  );
endinterface

// File: rtl/bus_device_fifo_ptr.sv
// -----------------------------------------------------------------------------
// bus_fifo_ptr
// Modulo-depth wrapping pointer; depth need not be a power of two.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (pointer -> 0)
//   inc   : advance pointer by one this cycle
//   ptr   : current pointer value, 0 .. depth-1
// -----------------------------------------------------------------------------
module bus_fifo_ptr #(
  parameter  int depth = 8,
  localparam int PW    = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (inc) begin
      // Explicit wrap so non-power-of-two depths stay in range.
      ptr <= (ptr == PW'(depth - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/bus_device_fifo.sv
// -----------------------------------------------------------------------------
// bus_device_fifo
// Per-device transmit FIFO in front of the bus arbiter. The device pushes
// packets; the bus sees a pending flag and a first-word-fall-through head
// packet and pops it once granted.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : bus_device_fifo_if.slave (push_in, D_in, pop, pndng, D_pop, full,
//           count, overflow, ovf_cnt)
// Optional feature: define FIFO_OVF_CNT_EN to get a saturating count of
// dropped pushes on ovf_cnt; otherwise ovf_cnt is held at zero.
// -----------------------------------------------------------------------------
module bus_device_fifo
  import bus_fifo_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic               clk,
  input  logic               reset,
  bus_device_fifo_if.slave   bus
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [pckg_sz-1:0] mem [depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count_reg;
  logic [CW-1:0]      count_next;
  logic               full_reg;
  logic               pndng_reg;
  logic               push_ok;
  logic               pop_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push
  // when it is popped. A pop on an empty FIFO is simply ignored.
  assign push_ok = bus.push_in && (!full_reg || bus.pop);
  assign pop_ok  = bus.pop && (count_reg != '0);

  bus_fifo_ptr #(.depth(depth)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  bus_fifo_ptr #(.depth(depth)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately left unreset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.D_in;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Status flags are registered from the next count so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      full_reg  <= 1'b0;
      pndng_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(depth));
      pndng_reg <= (count_next != '0);
    end
  end

  assign bus.count    = count_reg;
  assign bus.full     = full_reg;
  assign bus.pndng    = pndng_reg;
  assign bus.D_pop    = pndng_reg ? mem[rd_ptr] : '0;
  assign bus.overflow = bus.push_in && full_reg && !bus.pop;

`ifdef FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt_reg <= 8'h00;
    end else if (bus.overflow && (ovf_cnt_reg != 8'hFF)) begin
      ovf_cnt_reg <= ovf_cnt_reg + 8'h01;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_reg;
`else
  assign bus.ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_bus_device_fifo.sv
// -----------------------------------------------------------------------------
// tb_bus_device_fifo
// Self-checking bench for bus_device_fifo with a depth-8 and a depth-5
// instance. A queue model tracks each FIFO; a negedge process compares every
// output against it, and directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_bus_device_fifo;
  import bus_fifo_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bus_device_fifo_if #(.pckg_sz(16), .depth(8)) if8 ();
  bus_device_fifo_if #(.pckg_sz(16), .depth(5)) if5 ();

  bus_device_fifo #(.pckg_sz(16), .depth(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  bus_device_fifo #(.pckg_sz(16), .depth(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (if5.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] q8[$];
  logic [15:0] q5[$];
  int          ovf8 = 0;
  int          ovf5 = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Queue model: apply the accepted pop then the accepted push each edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q8.delete();
      q5.delete();
      ovf8 = 0;
      ovf5 = 0;
    end else begin
      begin
        bit p, w;
        p = if8.pop && (q8.size() != 0);
        w = if8.push_in && ((q8.size() < 8) || if8.pop);
        if (if8.push_in && !w && ovf8 < 255) ovf8++;
        if (p) void'(q8.pop_front());
        if (w) q8.push_back(if8.D_in);
      end
      begin
        bit p, w;
        p = if5.pop && (q5.size() != 0);
        w = if5.push_in && ((q5.size() < 5) || if5.pop);
        if (if5.push_in && !w && ovf5 < 255) ovf5++;
        if (p) void'(q5.pop_front());
        if (w) q5.push_back(if5.D_in);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("d8_count", 32'(if8.count), 32'(q8.size()));
      chk("d8_pndng", 32'(if8.pndng), 32'(q8.size() != 0));
      chk("d8_full",  32'(if8.full),  32'(q8.size() == 8));
      chk("d8_dpop",  32'(if8.D_pop), (q8.size() != 0) ? 32'(q8[0]) : 32'h0);
      chk("d8_ovf",   32'(if8.overflow), 32'(if8.push_in && q8.size() == 8 && !if8.pop));
      chk("d5_count", 32'(if5.count), 32'(q5.size()));
      chk("d5_pndng", 32'(if5.pndng), 32'(q5.size() != 0));
      chk("d5_full",  32'(if5.full),  32'(q5.size() == 5));
      chk("d5_dpop",  32'(if5.D_pop), (q5.size() != 0) ? 32'(q5[0]) : 32'h0);
      chk("d5_ovf",   32'(if5.overflow), 32'(if5.push_in && q5.size() == 5 && !if5.pop));
`ifdef FIFO_OVF_CNT_EN
      chk("d8_ovfcnt", 32'(if8.ovf_cnt), 32'(ovf8));
      chk("d5_ovfcnt", 32'(if5.ovf_cnt), 32'(ovf5));
`else
      chk("d8_ovfcnt", 32'(if8.ovf_cnt), 32'h0);
      chk("d5_ovfcnt", 32'(if5.ovf_cnt), 32'h0);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic op8(input logic ps, input logic [15:0] d, input logic pp);
    if8.push_in = ps;
    if8.D_in    = d;
    if8.pop     = pp;
    step();
    if8.push_in = 1'b0;
    if8.pop     = 1'b0;
    #1;
  endtask

  task automatic op5(input logic ps, input logic [15:0] d, input logic pp);
    if5.push_in = ps;
    if5.D_in    = d;
    if5.pop     = pp;
    step();
    if5.push_in = 1'b0;
    if5.pop     = 1'b0;
    #1;
  endtask

  initial begin
    logic [15:0] last;
    if8.push_in = 1'b0; if8.pop = 1'b0; if8.D_in = '0;
    if5.push_in = 1'b0; if5.pop = 1'b0; if5.D_in = '0;
    reset = 1'b0;
    step();
    step();
    chk("rst_count", 32'(if8.count), 32'h0);
    chk("rst_pndng", 32'(if8.pndng), 32'h0);
    chk("rst_full",  32'(if8.full),  32'h0);
    chk("rst_dpop",  32'(if8.D_pop), 32'h0);
    chk("rst_ovfc",  32'(if8.ovf_cnt), 32'h0);
    reset = 1'b1;

    // 1: single push then pop
    op8(1'b1, 16'h0312, 1'b0);
    chk("t1_pndng", 32'(if8.pndng), 32'h1);
    chk("t1_dpop",  32'(if8.D_pop), 32'h0312);
    chk("t1_count", 32'(if8.count), 32'h1);
    op8(1'b0, 16'h0, 1'b1);
    chk("t1_pndng_after", 32'(if8.pndng), 32'h0);
    chk("t1_dpop_after",  32'(if8.D_pop), 32'h0);
    $display("t1 single push/pop done checks=%0d", checks);

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 8; i++) op8(1'b1, 16'h0100 + 16'(i), 1'b0);
    chk("t2_full",  32'(if8.full),  32'h1);
    chk("t2_count", 32'(if8.count), 32'h8);
    if8.push_in = 1'b1; if8.D_in = 16'h0999;
    #1;
    chk("t2_ovf_pulse", 32'(if8.overflow), 32'h1);
    step();
    if8.push_in = 1'b0;
    #1;
    chk("t2_ovf_clear", 32'(if8.overflow), 32'h0);
    chk("t2_count_ovf", 32'(if8.count), 32'h8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_order", 32'(if8.D_pop), 32'h0100 + 32'(i));
      op8(1'b0, 16'h0, 1'b1);
    end
    chk("t2_empty", 32'(if8.pndng), 32'h0);
    $display("t2 fill/overflow/drain done checks=%0d", checks);

    // 3: full + simultaneous push/pop
    for (int i = 0; i < 8; i++) op8(1'b1, 16'h0100 + 16'(i), 1'b0);
    op8(1'b1, 16'hFFAA, 1'b1);
    chk("t3_count", 32'(if8.count), 32'h8);
    chk("t3_full",  32'(if8.full),  32'h1);
    last = 16'h0;
    for (int i = 0; i < 8; i++) begin
      last = if8.D_pop;
      if (i < 7) chk("t3_order", 32'(last), 32'h0101 + 32'(i));
      op8(1'b0, 16'h0, 1'b1);
    end
    chk("t3_bcast_pkt",  32'(last), 32'hFFAA);
    chk("t3_bcast_dest", 32'(dest_of(last).dest), 32'(BCAST_ID));
    $display("t3 full push+pop done checks=%0d", checks);

    // 4: empty + simultaneous push/pop, then pop while empty
    op8(1'b1, 16'h0205, 1'b1);
    chk("t4_count", 32'(if8.count), 32'h1);
    chk("t4_dpop",  32'(if8.D_pop), 32'h0205);
    op8(1'b0, 16'h0, 1'b1);
    op8(1'b0, 16'h0, 1'b1);
    chk("t4_count_empty", 32'(if8.count), 32'h0);
    chk("t4_pndng_empty", 32'(if8.pndng), 32'h0);
    chk("t4_ovf_empty",   32'(if8.overflow), 32'h0);
    $display("t4 empty push+pop done checks=%0d", checks);

    // 5: depth-5 wrap, then async reset mid-stream
    for (int i = 0; i < 3; i++) op5(1'b1, 16'h0500 + 16'(i), 1'b0);
    for (int j = 0; j < 12; j++) begin
      chk("t5_wrap_order", 32'(if5.D_pop), 32'h0500 + 32'(j));
      op5(1'b1, 16'h0503 + 16'(j), 1'b1);
    end
    chk("t5_count", 32'(if5.count), 32'h3);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_pndng", 32'(if5.pndng), 32'h0);
    chk("t5_rst_count", 32'(if5.count), 32'h0);
    chk("t5_rst_dpop",  32'(if5.D_pop), 32'h0);
    step();
    reset = 1'b1;
    $display("t5 wrap/reset done checks=%0d", checks);

    // 6: sustained overflow into a full FIFO
    for (int i = 0; i < 8; i++) op8(1'b1, 16'h0600 + 16'(i), 1'b0);
    if8.push_in = 1'b1; if8.D_in = 16'h06FF;
    for (int i = 0; i < 300; i++) step();
    if8.push_in = 1'b0;
    #1;
`ifdef FIFO_OVF_CNT_EN
    chk("t6_ovf_cnt", 32'(if8.ovf_cnt), 32'hFF);
`else
    chk("t6_ovf_cnt", 32'(if8.ovf_cnt), 32'h0);
`endif
    chk("t6_count", 32'(if8.count), 32'h8);
    chk("t6_head",  32'(if8.D_pop), 32'h0600);
    $display("t6 sustained overflow done checks=%0d", checks);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
